// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: the operation channel (in_*, x, y, funct)
// and the result channel (out_*, result, flags).
//
// Both channels use valid/ready. A transfer happens on a rising clk edge
// when valid and ready are both high. The source holds valid and its data
// stable until that edge. Ready may depend combinationally on the other
// side's ready, but never on valid.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [3:0]       funct;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             cmp;
  logic             zero;
  logic             carry;
  logic             err;

  modport slave (
    input  in_valid, x, y, funct, out_ready,
    output in_ready, out_valid, result, result_hi, cmp, zero, carry, err
  );

  modport master (
    output in_valid, x, y, funct, out_ready,
    input  in_ready, out_valid, result, result_hi, cmp, zero, carry, err
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU with status flags and an illegal-op flag.
// Define ALU_MUL_EN to add the iterative shift-add multiply (funct 1000).
module alu_pipe #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       reset,
  alu_pipe_if.slave  bus,
  output logic [1:0] dbg_state
);

  localparam logic [3:0] F_XOR = 4'b0001;
  localparam logic [3:0] F_OR  = 4'b0010;
  localparam logic [3:0] F_AND = 4'b0011;
  localparam logic [3:0] F_SUB = 4'b0100;
  localparam logic [3:0] F_ADD = 4'b0101;
  localparam logic [3:0] F_CMP = 4'b0110;
  localparam logic [3:0] F_SHR = 4'b0111;
  localparam logic [3:0] F_SH  = 4'b1010;
  localparam logic [3:0] F_SHL = 4'b1110;
`ifdef ALU_MUL_EN
  localparam logic [3:0] F_MUL = 4'b1000;
  localparam logic [SHAMT_W-1:0] MUL_LAST = SHAMT_W'(WIDTH - 1);
`endif
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_MUL_EN
    S_MUL  = 2'd1,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             cmp_q;
  logic             zero_q;
  logic             carry_q;
  logic             err_q;

  logic             in_ready_w;
  logic             accept;

  // Ready is high in IDLE, or in DONE when the held result leaves this cycle.
  assign in_ready_w = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
  assign accept     = bus.in_valid && in_ready_w;

  // Single-cycle datapath, evaluated on the operands offered this cycle.
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [SHAMT_W-1:0] sh_amt;
  logic [WIDTH-1:0]   op_val;
  logic               op_wr;
  logic               op_carry;
  logic               op_illegal;

  always_comb begin
    add_full   = {1'b0, bus.x} + {1'b0, bus.y};
    sub_full   = {1'b0, bus.x} - {1'b0, bus.y};
    sh_amt     = bus.y[SHAMT_W-1:0];
    op_val     = '0;
    op_wr      = 1'b1;
    op_carry   = 1'b0;
    op_illegal = 1'b0;
    case (bus.funct)
      F_ADD: begin
        op_val   = add_full[WIDTH-1:0];
        op_carry = add_full[WIDTH];
      end
      F_SUB: begin
        op_val   = sub_full[WIDTH-1:0];
        op_carry = sub_full[WIDTH];
      end
      F_XOR: op_val = bus.x ^ bus.y;
      F_AND: op_val = bus.x & bus.y;
      F_OR:  op_val = bus.x | bus.y;
      F_SHL: op_val = (bus.y >= W_VAL) ? '0 : (bus.x << bus.y);
      F_SHR: op_val = (bus.y >= W_VAL) ? '0 : (bus.x >> bus.y);
      F_SH:  op_val = bus.y[SHAMT_W] ? (bus.x >> sh_amt) : (bus.x << sh_amt);
      F_CMP: op_wr  = 1'b0;
`ifdef ALU_MUL_EN
      F_MUL: op_wr  = 1'b0;
`endif
      default: begin
        op_wr      = 1'b0;
        op_illegal = 1'b1;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  // Shift-add multiplier: low half of prod_q starts as the multiplier and
  // is shifted out one bit per cycle while partial sums enter from the top.
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nx;
  logic               is_mul;

  assign is_mul  = (bus.funct == F_MUL);
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prod_nx = {mul_sum, prod_q[WIDTH-1:1]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cmp_q       <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_MUL_EN
      result_hi_q <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (state)
`ifdef ALU_MUL_EN
        S_MUL: begin
          prod_q <= prod_nx;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == MUL_LAST) begin
            state       <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= prod_nx[WIDTH-1:0];
            result_hi_q <= prod_nx[2*WIDTH-1:WIDTH];
            zero_q      <= (prod_nx[WIDTH-1:0] == '0);
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
          end
        end
`endif
        default: begin
`ifdef ALU_MUL_EN
          if (accept && is_mul) begin
            state       <= S_MUL;
            out_valid_q <= 1'b0;
            mcand_q     <= bus.x;
            prod_q      <= {{WIDTH{1'b0}}, bus.y};
            cnt_q       <= '0;
          end else
`endif
          if (accept) begin
            state       <= S_DONE;
            out_valid_q <= 1'b1;
            err_q       <= op_illegal;
            if (op_wr) begin
              result_q <= op_val;
              zero_q   <= (op_val == '0);
              carry_q  <= op_carry;
`ifdef ALU_MUL_EN
              result_hi_q <= '0;
`endif
            end
            if (bus.funct == F_CMP) begin
              cmp_q <= (bus.x == bus.y);
            end
          end else if ((state == S_DONE) && bus.out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cmp       = cmp_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.err       = err_q;
`ifdef ALU_MUL_EN
  assign bus.result_hi = result_hi_q;
`else
  assign bus.result_hi = '0;
`endif
  assign dbg_state     = state;

endmodule
